lemon_ifu: RTL and testbench

Instruction fetch unit directly upstream of the LemonPC decode/execute datapath. Owns the architectural fetch PC, issues 32-bit instruction reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a 2-entry queue for the downstream stage. Supports redirects from execute/branch resolution, which flush the queue and discard any in-flight response.

---
 rtl/lemon_pkg.sv | 18 +
 rtl/lemon_fetch_fifo.sv | 58 +++++
 rtl/lemon_ifu.sv | 90 +++++++++
 tb/tb_lemon_ifu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_pkg.sv
// Shared types and constants for the LemonPC fetch path.
package lemon_pkg;

    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/lemon_fetch_fifo.sv
// Purpose: 2-entry fetch queue with flush; head entry held in a register.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: head_rdy pops the head; a push into a full queue is dropped unless a pop frees a slot.
module lemon_fetch_fifo
    import lemon_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push_vld,
    input  fetch_entry_t push_dat,
    output logic         head_vld,
    input  logic         head_rdy,
    output fetch_entry_t head_dat,
    output logic [1:0]   count
);

    fetch_entry_t tail_dat;
    logic         pop;
    logic         push_ok;

    assign head_vld = (count != 2'd0);
    assign pop      = head_vld && head_rdy;
    assign push_ok  = push_vld && ((count != 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head_dat <= '0;
            tail_dat <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push_ok, pop})
                2'b10: begin
                    if (count == 2'd0) head_dat <= push_dat;
                    else               tail_dat <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // head keeps its last value when the queue drains
                    if (count == 2'd2) head_dat <= tail_dat;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_dat <= push_dat;
                    end else begin
                        head_dat <= tail_dat;
                        tail_dat <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lemon_ifu.sv
// Purpose: instruction fetch unit; owns fetch PC, one outstanding imem read, 2-entry output queue.
// Latency: response in cycle N appears on out_* in cycle N+1; sustained rate one fetch per 2 cycles.
// Backpressure: requests stall while the queue holds 2 entries; redirects flush and kill in-flight data.
module lemon_ifu
    import lemon_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc
);

    ifu_state_t      state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            kill;
    logic            req_hs;
    logic            resp_hit;
    logic            push_vld;
    logic [1:0]      q_count;
    fetch_entry_t    push_dat;
    fetch_entry_t    head_dat;

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        case (state)
            BOOT: state_nxt = REQ;
            REQ: begin
                imem_req_valid = (q_count != 2'd2);
                if (imem_req_valid && imem_req_ready) state_nxt = WAIT;
            end
            WAIT: if (imem_resp_valid) state_nxt = REQ;
            default: state_nxt = BOOT;
        endcase
        req_hs   = imem_req_valid && imem_req_ready;
        resp_hit = (state == WAIT) && imem_resp_valid;
        // a redirect must still wait out any request left in flight
        if (redirect_valid)
            state_nxt = ((state == WAIT && !imem_resp_valid) || req_hs) ? WAIT : REQ;
        push_vld = resp_hit && !kill && !redirect_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            kill     <= 1'b0;
        end else begin
            if (req_hs) req_pc <= fetch_pc;
            if (redirect_valid)  fetch_pc <= redirect_pc & ~XLEN'(3);
            else if (req_hs)     fetch_pc <= fetch_pc + XLEN'(4);
            if (redirect_valid)  kill <= (state_nxt == WAIT);
            else if (resp_hit)   kill <= 1'b0;
        end
    end

    assign imem_req_addr = fetch_pc;
    assign push_dat      = '{pc: req_pc, inst: imem_resp_data};

    lemon_fetch_fifo u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .head_vld (out_valid),
        .head_rdy (out_ready),
        .head_dat (head_dat),
        .count    (q_count)
    );

    assign out_inst = head_dat.inst;
    assign out_pc   = head_dat.pc;

endmodule

// File: tb/tb_lemon_ifu.sv
// Bench for lemon_ifu: cycle table after reset, directed corner sequences, then randomized
// traffic checked against an address-sequence model with an instruction-memory responder.
module tb_lemon_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    always #5 clk = ~clk;

    lemon_ifu dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc)
    );

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    int n_tests = 0;
    int n_fail  = 0;

    // memory responder and reference model state
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int          wait_cnt = 0;
    int          resp_delay = 1;
    logic        chk_en = 1'b0;
    logic [63:0] exp_req = '0;
    logic [63:0] exp_out = '0;
    int          pops = 0;

    typedef struct {
        logic        rdy;
        logic        rvld;
        logic [31:0] rdat;
        logic        ordy;
        logic        exp_rq;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tbl[8];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic rdy, input logic ordy, input logic redir, input logic [63:0] rpc);
        logic        acc, rsp, pop;
        logic [63:0] aaddr;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rsp = pend && (wait_cnt == 0);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? inst_of(pend_addr) : 32'h0;
        acc   = imem_req_valid && rdy;
        aaddr = imem_req_addr;
        pop   = out_valid && ordy;
        if (chk_en) begin
            if (pend) chk("one_outstanding", imem_req_valid, 0);
            if (acc) begin
                chk("req_addr", aaddr, exp_req);
                exp_req = exp_req + 64'd4;
            end
            if (pop) begin
                chk("out_pc", out_pc, exp_out);
                chk("out_inst", out_inst, inst_of(exp_out));
                exp_out = exp_out + 64'd4;
                pops++;
            end
            if (redir) begin
                exp_req = rpc & ~64'h3;
                exp_out = rpc & ~64'h3;
            end
        end
        @(posedge clk);
        #1;
        if (rsp) pend = 1'b0;
        else if (pend) wait_cnt--;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = aaddr;
            wait_cnt  = resp_delay - 1;
        end
    endtask

    task automatic settle();
        int n = 0;
        while (!(!pend && !out_valid && imem_req_valid) && n < 40) begin
            tick(1'b0, 1'b1, 1'b0, 64'h0);
            n++;
        end
        chk("settle", (!pend && !out_valid && imem_req_valid), 1);
    endtask

    initial begin
        //           rdy  rvld  rdat          ordy  rq   addr                  ov   pc                    inst
        tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 64'h8000_0000, 1'b0, 64'h0,          32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0,          32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h00100093, 1'b1, 1'b0, 64'h8000_0004, 1'b0, 64'h0,          32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000, 32'h00100093};
        tbl[4] = '{1'b0, 1'b1, 32'h00200113, 1'b1, 1'b0, 64'h8000_0008, 1'b0, 64'h8000_0000, 32'h00100093};
        tbl[5] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h00200113};
        tbl[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004, 32'h00200113};
        tbl[7] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'h8000_0008, 1'b0, 64'h8000_0004, 32'h00200113};

        rst_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        rst_n = 1'b1;

        // cycle table starting at cycle 0 (BOOT)
        for (int i = 0; i < 8; i++) begin
            imem_req_ready  = tbl[i].rdy;
            imem_resp_valid = tbl[i].rvld;
            imem_resp_data  = tbl[i].rdat;
            out_ready       = tbl[i].ordy;
            chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].exp_rq);
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_out_inst", i), out_inst, tbl[i].exp_inst);
            @(posedge clk);
            #1;
        end

        // backpressure: queue fills to two, requests stop, release drains in order
        resp_delay = 1;
        repeat (10) tick(1'b1, 1'b0, 1'b0, 64'h0);
        chk("bp_req_valid_full", imem_req_valid, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head_pc", out_pc, 64'h8000_0008);
        chk("bp_head_inst", out_inst, inst_of(64'h8000_0008));
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        chk("bp_second_pc", out_pc, 64'h8000_000C);
        chk("bp_second_valid", out_valid, 1);
        chk("bp_resume_valid", imem_req_valid, 1);
        chk("bp_resume_addr", imem_req_addr, 64'h8000_0010);
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        chk("bp_drained", out_valid, 0);
        settle();

        // redirect while waiting on a response
        resp_delay = 3;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b1, 1'b1, 64'h8000_1002);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_req_valid", imem_req_valid, 0);
        chk("rw_req_addr", imem_req_addr, 64'h8000_1000);
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        chk("rw_dropped", out_valid, 0);
        chk("rw_new_req", imem_req_valid, 1);
        chk("rw_new_addr", imem_req_addr, 64'h8000_1000);
        resp_delay = 1;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rw_target_valid", out_valid, 1);
        chk("rw_target_pc", out_pc, 64'h8000_1000);
        chk("rw_target_inst", out_inst, inst_of(64'h8000_1000));
        settle();

        // redirect in the same cycle as a request handshake
        resp_delay = 1;
        tick(1'b1, 1'b1, 1'b1, 64'h8000_2000);
        chk("rh_req_valid", imem_req_valid, 0);
        chk("rh_req_addr", imem_req_addr, 64'h8000_2000);
        chk("rh_out_valid", out_valid, 0);
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        chk("rh_dropped", out_valid, 0);
        chk("rh_new_req", imem_req_valid, 1);
        chk("rh_new_addr", imem_req_addr, 64'h8000_2000);
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rh_target_valid", out_valid, 1);
        chk("rh_target_pc", out_pc, 64'h8000_2000);
        settle();

        // reset while waiting with one queued entry; late response must be ignored
        resp_delay = 1;
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        resp_delay = 2;
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        chk("rs_queued", out_valid, 1);
        chk("rs_waiting", imem_req_valid, 0);
        rst_n = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_req_valid", imem_req_valid, 0);
        chk("rs_req_addr", imem_req_addr, RST_PC);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rs_late_ignored", out_valid, 0);
        chk("rs_restart_valid", imem_req_valid, 1);
        chk("rs_restart_addr", imem_req_addr, RST_PC);
        resp_delay = 1;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        chk("rs_first_valid", out_valid, 1);
        chk("rs_first_pc", out_pc, RST_PC);
        settle();

        // randomized traffic against the sequential-PC model
        chk_en  = 1'b1;
        exp_req = RST_PC + 64'd4;
        exp_out = RST_PC + 64'd4;
        for (int i = 0; i < 3000; i++) begin
            logic        rdy, ordy, redir;
            logic [63:0] rpc;
            resp_delay = $urandom_range(1, 5);
            rdy   = ($urandom % 10) < 3;
            redir = ($urandom % 50) == 0;
            ordy  = redir ? 1'b0 : 1'($urandom % 2);
            rpc   = {$urandom, $urandom};
            if (($urandom % 4) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF4 | 64'($urandom % 4);
            tick(rdy, ordy, redir, rpc);
        end
        chk_en = 1'b0;
        chk("rand_progress", (pops > 100), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
